ahb_lite_sram_slave: RTL and testbench
======================================

// Module: ahb_lite_sram_slave
// PURPOSE
//  AHB-Lite slave directly downstream of the ahb_if bus; consumes master address/data phases, returns HRDATA/HREADYOUT/HRESP.
//  Word-organised SRAM with byte-lane writes, programmable wait states and two-cycle ERROR response.
//  Acts as the reference DUT/memory model that the AHB VIP master drives; synthesizable.
// PARAMETERS
//  AHB_ADDR_WIDTH  32    HADDR width
//  AHB_DATA_WIDTH  32    HWDATA/HRDATA width (32 or 64)
//  MEM_DEPTH       1024  number of AHB_DATA_WIDTH words; byte range 0..MEM_DEPTH*(AHB_DATA_WIDTH/8)-1
//  WAIT_STATES     0     HREADYOUT-low cycles inserted per OKAY data phase (0..15)
// PORTS
//  HCLK       in   1               bus clock, all state on rising edge
//  HRESETn    in   1               asynchronous active-low reset
//  HSEL       in   1               slave select
//  HADDR      in   AHB_ADDR_WIDTH  byte address
//  HTRANS     in   2               IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1               1=write
//  HSIZE      in   3               transfer size, bytes = 1<<HSIZE
//  HBURST     in   3               accepted, ignored (each beat independent)
//  HPROT      in   4               accepted, ignored
//  HMASTLOCK  in   1               accepted, ignored
//  HWDATA     in   AHB_DATA_WIDTH  write data (data phase)
//  HREADY     in   1               bus-level ready (mux of all HREADYOUT)
//  HREADYOUT  out  1               slave ready
//  HRESP      out  1               0=OKAY 1=ERROR
//  HRDATA     out  AHB_DATA_WIDTH  read data
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0; captured phase regs cleared; memory NOT cleared.
//  Address phase accepted when HSEL & HREADY & HTRANS[1]; capture HADDR,HWRITE,HSIZE. IDLE/BUSY or !HSEL -> zero-wait OKAY.
//  Error check at capture: addr >= range, HSIZE > log2(AHB_DATA_WIDTH/8), or HADDR not aligned to size -> ERROR path.
//  FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE: accepted OK -> WAIT if WAIT_STATES>0 else DATA; accepted ERR -> ERR1; else stay.
//   WAIT: HREADYOUT=0, HRESP=0; down-counter from WAIT_STATES; at count==1 -> DATA.
//   DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle; pipelined next address phase evaluated as IDLE does.
//   ERR1: HREADYOUT=0, HRESP=1 -> ERR2.  ERR2: HREADYOUT=1, HRESP=1; next address phase evaluated as IDLE does.
//  Latency: read/write data phase = WAIT_STATES+1 cycles; ERROR always 2 cycles; back-to-back transfers with no bubble.
//  Writes: HWDATA sampled in final DATA cycle; byte enables from HSIZE and HADDR low bits, little-endian lanes; no memory update on ERROR.
//  Reads: HRDATA = full word at captured address, valid in DATA cycle; HRDATA=0 in all other cycles.
//  Write then read same address back-to-back: read returns new data (write commits before read data phase).
//  Address phase during WAIT/ERR1 is ignored (HREADY low); master must hold it, per protocol.
//  Reset asserted mid data phase: transfer abandoned, partial write never committed.
// STRUCTURE
//  ahb_pkg: htrans_t enum, HRESP_OKAY/HRESP_ERROR, hsize constants, ahb_slv_state_t enum.
//  Sub-module ahb_sram_bytelane_mem: MEM_DEPTH x AHB_DATA_WIDTH array, per-byte write enable, combinational read.
//  Top: address-phase capture regs, error decode, wait counter, FSM, byte-enable decode.
// TESTING
//  Reset: HRESETn=0 mid WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; mem word kept.
//  WAIT_STATES=0: write 0xDEADBEEF @0x10 word, read @0x10 back-to-back -> HRDATA=0xDEADBEEF, no HREADYOUT low.
//  WAIT_STATES=2: word read @0x4 -> HREADYOUT low exactly 2 cycles, data on 3rd data-phase cycle.
//  Byte write 0xAA (HSIZE=0) @0x13 over word 0x11223344 @0x10 -> read 0xAA223344.
//  Read @range end (0x1000, MEM_DEPTH=1024) -> cycle1 HREADYOUT=0 HRESP=1, cycle2 HREADYOUT=1 HRESP=1.
//  Halfword write @0x01 (misaligned) -> 2-cycle ERROR, memory unchanged; HTRANS=IDLE with HSEL=1 -> OKAY, zero wait.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_t;

endpackage

// File: rtl/ahb_sram_bytelane_mem.sv
// Word-organised SRAM array with per-byte write enables and combinational read.
module ahb_sram_bytelane_mem #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_sys,
  input  logic [IDX_W-1:0]      addr,
  input  logic [BYTES-1:0]      be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so data survives a bus reset.
  always_ff @(posedge clk_sys) begin
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, error decode, wait-state counter,
// response FSM and little-endian byte-lane write enables.
//
//   state | meaning
//   IDLE  | no data phase in progress, HREADYOUT=1
//   WAIT  | OKAY data phase stalled, down-counter running
//   DATA  | final OKAY data-phase cycle, write commits / read data valid
//   ERR1  | first ERROR cycle, HREADYOUT=0
//   ERR2  | second ERROR cycle, HREADYOUT=1
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic                      HMASTLOCK,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA
);

  localparam int BYTES     = AHB_DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [AHB_ADDR_WIDTH:0] MEM_BYTES = (AHB_ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  ahb_slv_state_t state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [2:0]           size_q;
  logic                 write_q;

  htrans_t              trans;
  logic                 phase_open;
  logic                 accept;
  logic                 phase_err;
  logic [LANE_BITS-1:0] size_mask;
  logic [BYTES-1:0]     be;
  logic [BYTES-1:0]     mem_be;
  logic [AHB_DATA_WIDTH-1:0] rdata;
  logic                 unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign trans      = htrans_t'(HTRANS);
  assign phase_open = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = phase_open && HSEL && HREADY &&
                      ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < LANE_BITS; i++) begin
      if (i < int'(HSIZE)) size_mask[i] = 1'b1;
    end
  end

  assign phase_err = ({1'b0, HADDR} >= MEM_BYTES) ||
                     (HSIZE > 3'(LANE_BITS)) ||
                     (|(HADDR[LANE_BITS-1:0] & size_mask));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= HADDR[LANE_BITS +: IDX_W];
        lane_q  <= HADDR[LANE_BITS-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (state_q == ST_DATA && !write_q) HRDATA = rdata;
        if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
        state_d = ST_IDLE;
        if (accept) begin
          if (phase_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 4'd1) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lanes covered by an aligned transfer share the same (lane >> size) group.
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) begin
      if ((b >> size_q) == (int'(lane_q) >> size_q)) be[b] = 1'b1;
    end
  end

  assign mem_be = (state_q == ST_DATA && write_q) ? be : '0;

  ahb_sram_bytelane_mem #(
    .DATA_WIDTH (AHB_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk_sys (HCLK),
    .addr    (idx_q),
    .be      (mem_be),
    .wdata   (HWDATA),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: directed table, hand sequences and random
// pipelined traffic against a byte-array reference model, at 0 and 2 wait states.
module tb_ahb_lite_sram_slave;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          lows;
  } res_t;

  typedef struct packed {
    xfer_t       x;
    logic        has_phase;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk, rst_n;
  logic        hsel[2];
  logic [31:0] haddr[2];
  logic [1:0]  htrans[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [2:0]  hburst[2];
  logic [3:0]  hprot[2];
  logic        hmastlock[2];
  logic [31:0] hwdata[2];
  logic        hreadyout[2];
  logic        hresp[2];
  logic [31:0] hrdata[2];

  logic [7:0]  mdl [2][4096];
  xfer_t       seq_q[$];
  res_t        res_q[$];
  int          vectors, miscompares;

  localparam xfer_t IDLE_X = '{sel:1'b0, trans:2'b00, wr:1'b0, size:3'd0, addr:32'h0, wdata:32'h0};

  ahb_lite_sram_slave #(.WAIT_STATES(WS0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
    .HMASTLOCK(hmastlock[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_lite_sram_slave #(.WAIT_STATES(WS1)) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
    .HMASTLOCK(hmastlock[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic bit is_err(xfer_t x);
    if (x.addr >= 32'h1000) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    return (x.addr % (32'd1 << x.size)) != 0;
  endfunction

  function automatic logic [31:0] mdl_word(int d, logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a & ~32'h3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[d][base + i];
    return w;
  endfunction

  task automatic mdl_write(int d, xfer_t x);
    int a;
    for (int i = 0; i < (1 << x.size); i++) begin
      a = int'(x.addr) + i;
      mdl[d][a] = x.wdata[8*(a % 4) +: 8];
    end
  endtask

  task automatic drive(int d, xfer_t x);
    hsel[d]      = x.sel;
    haddr[d]     = x.addr;
    htrans[d]    = x.trans;
    hwrite[d]    = x.wr;
    hsize[d]     = x.size;
    hburst[d]    = 3'($urandom);
    hprot[d]     = 4'($urandom);
    hmastlock[d] = 1'($urandom);
  endtask

  // Drives seq_q on bus d with full pipelining; checks every cycle against the model.
  task automatic run(int d);
    xfer_t ap, dp;
    bit    dp_v, ap_pending, rdy, exp_rdy, exp_resp;
    logic [31:0] exp_rd;
    int    k, budget;
    res_t  r;
    dp_v = 1'b0; k = 0; budget = 0;
    dp = IDLE_X;
    if (seq_q.size() > 0) begin ap = seq_q.pop_front(); ap_pending = 1'b1; end
    else begin ap = IDLE_X; ap_pending = 1'b0; end
    drive(d, ap);
    while ((seq_q.size() > 0 || ap_pending || dp_v) && budget < 3000) begin
      @(negedge clk);
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0;
      if (dp_v) begin
        if (is_err(dp)) begin
          exp_rdy  = (k == 1);
          exp_resp = 1'b1;
        end else begin
          exp_rdy = (k == ws_of(d));
          if (exp_rdy && !dp.wr) exp_rd = mdl_word(d, dp.addr);
        end
      end
      chk($sformatf("d%0d_hreadyout", d), 32'(hreadyout[d]), 32'(exp_rdy));
      chk($sformatf("d%0d_hresp", d), 32'(hresp[d]), 32'(exp_resp));
      chk($sformatf("d%0d_hrdata", d), hrdata[d], exp_rd);
      rdy = hreadyout[d];
      if (rdy && dp_v) begin
        r.err = hresp[d]; r.rdata = hrdata[d]; r.lows = k;
        res_q.push_back(r);
        if (!is_err(dp) && dp.wr) mdl_write(d, dp);
        dp_v = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy) begin
        k = 0;
        if (ap.sel && ap.trans[1]) begin
          dp = ap; dp_v = 1'b1;
          hwdata[d] = ap.wr ? ap.wdata : $urandom();
        end else begin
          hwdata[d] = $urandom();
        end
        if (seq_q.size() > 0) begin ap = seq_q.pop_front(); ap_pending = 1'b1; end
        else begin ap = IDLE_X; ap_pending = 1'b0; end
        drive(d, ap);
      end else begin
        k++;
      end
      budget++;
    end
    if (budget >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL d%0d_run_timeout: got %0d cycles expected fewer than 3000", d, budget);
      seq_q.delete();
    end
  endtask

  function automatic xfer_t mkx(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                                logic [31:0] a, logic [31:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
    return x;
  endfunction

  function automatic vec_t mkv(xfer_t x, logic ph, logic er, logic [31:0] rd);
    vec_t v;
    v.x = x; v.has_phase = ph; v.exp_err = er; v.exp_rdata = rd;
    return v;
  endfunction

  function automatic xfer_t rnd_item();
    xfer_t x;
    int r;
    r = $urandom_range(0, 99);
    x.sel   = (r >= 5);
    x.trans = (r < 12) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    x.wr    = 1'($urandom);
    x.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    case ($urandom_range(0, 9))
      0:       x.addr = 32'h1000 + $urandom_range(0, 255);
      1:       x.addr = 32'hFFC + $urandom_range(0, 3);
      default: x.addr = $urandom_range(0, 63);
    endcase
    x.wdata = $urandom();
    return x;
  endfunction

  vec_t tbl [20];
  res_t r;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin drive(d, IDLE_X); hwdata[d] = '0; end

    tbl[0]  = mkv(mkx(1, 2'b10, 1, 3'd2, 32'h10,   32'hDEADBEEF), 1, 0, 32'h0);
    tbl[1]  = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h10,   32'h0),        1, 0, 32'hDEADBEEF);
    tbl[2]  = mkv(mkx(1, 2'b11, 1, 3'd2, 32'h10,   32'h11223344), 1, 0, 32'h0);
    tbl[3]  = mkv(mkx(1, 2'b10, 1, 3'd0, 32'h13,   32'hAA000000), 1, 0, 32'h0);
    tbl[4]  = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h10,   32'h0),        1, 0, 32'hAA223344);
    tbl[5]  = mkv(mkx(1, 2'b10, 1, 3'd2, 32'h0,    32'h55667788), 1, 0, 32'h0);
    tbl[6]  = mkv(mkx(1, 2'b10, 1, 3'd1, 32'h1,    32'hFFFFFFFF), 1, 1, 32'h0);
    tbl[7]  = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h0,    32'h0),        1, 0, 32'h55667788);
    tbl[8]  = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h1000, 32'h0),        1, 1, 32'h0);
    tbl[9]  = mkv(mkx(1, 2'b10, 0, 3'd3, 32'h8,    32'h0),        1, 1, 32'h0);
    tbl[10] = mkv(mkx(1, 2'b10, 1, 3'd2, 32'h20,   32'h00000000), 1, 0, 32'h0);
    tbl[11] = mkv(mkx(1, 2'b10, 1, 3'd1, 32'h22,   32'hBEEF0000), 1, 0, 32'h0);
    tbl[12] = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h20,   32'h0),        1, 0, 32'hBEEF0000);
    tbl[13] = mkv(mkx(1, 2'b10, 1, 3'd2, 32'hFFC,  32'hCAFEF00D), 1, 0, 32'h0);
    tbl[14] = mkv(mkx(1, 2'b10, 0, 3'd2, 32'hFFC,  32'h0),        1, 0, 32'hCAFEF00D);
    tbl[15] = mkv(mkx(1, 2'b00, 1, 3'd2, 32'h0,    32'h0),        0, 0, 32'h0);
    tbl[16] = mkv(mkx(0, 2'b10, 1, 3'd2, 32'h0,    32'h0BADBAD0), 0, 0, 32'h0);
    tbl[17] = mkv(mkx(1, 2'b10, 0, 3'd2, 32'h0,    32'h0),        1, 0, 32'h55667788);
    tbl[18] = mkv(mkx(1, 2'b01, 1, 3'd2, 32'h0,    32'h0),        0, 0, 32'h0);
    tbl[19] = mkv(mkx(1, 2'b10, 0, 3'd0, 32'h11,   32'h0),        1, 0, 32'hAA223344);

    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_hreadyout", d), 32'(hreadyout[d]), 32'h1);
      chk($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'h0);
      chk($sformatf("d%0d_rst_hrdata", d), hrdata[d], 32'h0);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Give the model a known image of every word the later traffic can reach.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) seq_q.push_back(mkx(1, 2'b10, 1, 3'd2, 32'(4*w), $urandom()));
      seq_q.push_back(mkx(1, 2'b10, 1, 3'd2, 32'hFFC, $urandom()));
      run(d);
      res_q.delete();
    end

    for (int i = 0; i < 20; i++) begin
      seq_q.push_back(tbl[i].x);
      run(0);
      if (tbl[i].has_phase) begin
        if (res_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tbl%0d_phase: got no data phase expected one", i);
        end else begin
          r = res_q.pop_front();
          chk($sformatf("tbl%0d_resp", i), 32'(r.err), 32'(tbl[i].exp_err));
          chk($sformatf("tbl%0d_lows", i), 32'(r.lows), tbl[i].exp_err ? 32'd1 : 32'd0);
          if (!tbl[i].exp_err && !tbl[i].x.wr)
            chk($sformatf("tbl%0d_rdata", i), r.rdata, tbl[i].exp_rdata);
        end
      end else begin
        chk($sformatf("tbl%0d_nophase", i), 32'(res_q.size()), 32'd0);
      end
      res_q.delete();
    end

    // Back-to-back write then read of the same word, zero wait states.
    seq_q.push_back(mkx(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEADBEEF));
    seq_q.push_back(mkx(1, 2'b11, 0, 3'd2, 32'h10, 32'h0));
    run(0);
    chk("b2b_count", 32'(res_q.size()), 32'd2);
    if (res_q.size() == 2) begin
      chk("b2b_wr_lows", 32'(res_q[0].lows), 32'd0);
      chk("b2b_rd_lows", 32'(res_q[1].lows), 32'd0);
      chk("b2b_rd_data", res_q[1].rdata, 32'hDEADBEEF);
    end
    res_q.delete();

    // Two wait states: stall exactly two cycles before the data cycle.
    seq_q.push_back(mkx(1, 2'b10, 1, 3'd2, 32'h4, 32'h0BADF00D));
    seq_q.push_back(mkx(1, 2'b10, 0, 3'd2, 32'h4, 32'h0));
    run(1);
    chk("ws2_count", 32'(res_q.size()), 32'd2);
    if (res_q.size() == 2) begin
      chk("ws2_wr_lows", 32'(res_q[0].lows), 32'd2);
      chk("ws2_rd_lows", 32'(res_q[1].lows), 32'd2);
      chk("ws2_rd_data", res_q[1].rdata, 32'h0BADF00D);
    end
    res_q.delete();

    // Reset during WAIT: outputs clear immediately and the write never lands.
    drive(1, mkx(1, 2'b10, 1, 3'd2, 32'h4, 32'h12345678));
    @(posedge clk); #1;
    hwdata[1] = 32'h12345678;
    drive(1, IDLE_X);
    @(negedge clk);
    chk("rstwait_in_wait", 32'(hreadyout[1]), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstwait_hreadyout", 32'(hreadyout[1]), 32'h1);
    chk("rstwait_hresp", 32'(hresp[1]), 32'h0);
    chk("rstwait_hrdata", hrdata[1], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    seq_q.push_back(mkx(1, 2'b10, 0, 3'd2, 32'h4, 32'h0));
    run(1);
    chk("rstwait_count", 32'(res_q.size()), 32'd1);
    if (res_q.size() == 1) chk("rstwait_mem_kept", res_q[0].rdata, 32'h0BADF00D);
    res_q.delete();

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 250; n++) seq_q.push_back(rnd_item());
      run(d);
      res_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
